// File: rtl/assoc_wb_cache.sv
// assoc_wb_cache: N-way set-associative, write-back, write-allocate cache. One line holds one
// DATA_WIDTH word. Replacement is per-set round-robin, but an invalid way is always used first.
// Only one request is in flight at a time.
//
// Ports:
//   clk, rst_n                  clock and asynchronous active-low reset
//   cpu_req_valid/cpu_req_ready CPU request handshake (ready only in IDLE)
//   cpu_addr, cpu_we, cpu_wdata request byte address, write enable and write data
//   cpu_rsp_valid, cpu_rdata    one-cycle response pulse; rdata holds between responses
//   hit, miss                   hit qualifies the response; miss pulses in COMPARE
//   mem_req_valid, mem_req_we   backing-memory request (we=1 writeback, we=0 refill)
//   mem_addr, mem_wdata         line address (offset bits zero) and writeback data
//   mem_ack, mem_rdata          one-cycle transfer-done pulse and refill data
module assoc_wb_cache #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned ADDR_WIDTH   = 16,
    parameter int unsigned TAG_WIDTH    = 10,
    parameter int unsigned OFFSET_WIDTH = 2,
    parameter int unsigned WAYS         = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cpu_req_valid,
    output logic                  cpu_req_ready,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic                  cpu_we,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic                  cpu_rsp_valid,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  hit,
    output logic                  miss,
    output logic                  mem_req_valid,
    output logic                  mem_req_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);
    localparam int unsigned INDEX_WIDTH = ADDR_WIDTH - TAG_WIDTH - OFFSET_WIDTH;
    localparam int unsigned SETS        = 1 << INDEX_WIDTH;
    localparam int unsigned WAY_BITS    = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [2:0] {StIdle, StCompare, StWriteback, StRefill, StRespond} state_e;

    state_e                 state_q;
    logic [WAYS-1:0]        valid_q [SETS];
    logic [WAYS-1:0]        dirty_q [SETS];
    logic [WAY_BITS-1:0]    rr_q    [SETS];
    logic [TAG_WIDTH-1:0]   tag_q   [SETS][WAYS];
    logic [DATA_WIDTH-1:0]  data_q  [SETS][WAYS];

    logic [TAG_WIDTH-1:0]   req_tag_q;
    logic [INDEX_WIDTH-1:0] req_idx_q;
    logic                   req_we_q;
    logic [DATA_WIDTH-1:0]  req_wdata_q;
    logic                   req_hit_q;
    logic [WAY_BITS-1:0]    way_q;      // hit way on a hit, victim way on a miss
    logic                   from_rr_q;  // victim was chosen by the round-robin pointer

    // The lookup runs in IDLE on the live address so COMPARE can present registered results.
    logic [INDEX_WIDTH-1:0] lk_idx;
    logic [TAG_WIDTH-1:0]   lk_tag;
    logic                   lk_hit;
    logic                   lk_free;
    logic [WAY_BITS-1:0]    lk_hit_way;
    logic [WAY_BITS-1:0]    lk_victim;
    logic [DATA_WIDTH-1:0]  lk_data;
    logic                   unused_offset;

    assign lk_idx        = cpu_addr[OFFSET_WIDTH +: INDEX_WIDTH];
    assign lk_tag        = cpu_addr[ADDR_WIDTH-1 -: TAG_WIDTH];
    assign lk_data       = data_q[lk_idx][lk_hit_way];
    assign unused_offset = ^cpu_addr[OFFSET_WIDTH-1:0];

    always_comb begin
        lk_hit     = 1'b0;
        lk_hit_way = '0;
        lk_free    = 1'b0;
        lk_victim  = rr_q[lk_idx];
        for (int w = 0; w < int'(WAYS); w++) begin
            if (!lk_hit && valid_q[lk_idx][w] && tag_q[lk_idx][w] == lk_tag) begin
                lk_hit     = 1'b1;
                lk_hit_way = WAY_BITS'(w);
            end
            if (!lk_free && !valid_q[lk_idx][w]) begin
                lk_free   = 1'b1;
                lk_victim = WAY_BITS'(w);
            end
        end
    end

    logic [TAG_WIDTH-1:0]  vic_tag;
    logic [DATA_WIDTH-1:0] vic_data;
    logic                  vic_dirty;

    assign vic_tag   = tag_q[req_idx_q][way_q];
    assign vic_data  = data_q[req_idx_q][way_q];
    assign vic_dirty = valid_q[req_idx_q][way_q] && dirty_q[req_idx_q][way_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            for (int s = 0; s < int'(SETS); s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                rr_q[s]    <= '0;
            end
            req_tag_q     <= '0;
            req_idx_q     <= '0;
            req_we_q      <= 1'b0;
            req_wdata_q   <= '0;
            req_hit_q     <= 1'b0;
            way_q         <= '0;
            from_rr_q     <= 1'b0;
            cpu_req_ready <= 1'b0;
            cpu_rsp_valid <= 1'b0;
            cpu_rdata     <= '0;
            hit           <= 1'b0;
            miss          <= 1'b0;
            mem_req_valid <= 1'b0;
            mem_req_we    <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
        end else begin
            cpu_rsp_valid <= 1'b0;
            hit           <= 1'b0;
            miss          <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (cpu_req_valid && cpu_req_ready) begin
                        req_tag_q     <= lk_tag;
                        req_idx_q     <= lk_idx;
                        req_we_q      <= cpu_we;
                        req_wdata_q   <= cpu_wdata;
                        req_hit_q     <= lk_hit;
                        way_q         <= lk_hit ? lk_hit_way : lk_victim;
                        from_rr_q     <= !lk_hit && !lk_free;
                        cpu_req_ready <= 1'b0;
                        // Response/miss flags are registered here so they are valid in COMPARE.
                        if (lk_hit) begin
                            cpu_rsp_valid <= 1'b1;
                            hit           <= 1'b1;
                            cpu_rdata     <= cpu_we ? cpu_wdata : lk_data;
                        end else begin
                            miss <= 1'b1;
                        end
                        state_q <= StCompare;
                    end else begin
                        cpu_req_ready <= 1'b1;
                    end
                end
                StCompare: begin
                    if (req_hit_q) begin
                        if (req_we_q) dirty_q[req_idx_q][way_q] <= 1'b1;
                        cpu_req_ready <= 1'b1;
                        state_q       <= StIdle;
                    end else if (vic_dirty) begin
                        mem_req_valid <= 1'b1;
                        mem_req_we    <= 1'b1;
                        mem_addr      <= {vic_tag, req_idx_q, {OFFSET_WIDTH{1'b0}}};
                        mem_wdata     <= vic_data;
                        state_q       <= StWriteback;
                    end else begin
                        mem_req_valid <= 1'b1;
                        mem_req_we    <= 1'b0;
                        mem_addr      <= {req_tag_q, req_idx_q, {OFFSET_WIDTH{1'b0}}};
                        state_q       <= StRefill;
                    end
                end
                StWriteback: begin
                    if (mem_ack) begin
                        mem_req_valid <= 1'b0;
                        state_q       <= StRefill;
                    end
                end
                StRefill: begin
                    // After a writeback, valid drops for one cycle before the refill is issued.
                    if (!mem_req_valid) begin
                        mem_req_valid <= 1'b1;
                        mem_req_we    <= 1'b0;
                        mem_addr      <= {req_tag_q, req_idx_q, {OFFSET_WIDTH{1'b0}}};
                    end else if (mem_ack) begin
                        mem_req_valid              <= 1'b0;
                        valid_q[req_idx_q][way_q]  <= 1'b1;
                        dirty_q[req_idx_q][way_q]  <= req_we_q;
                        if (from_rr_q) begin
                            rr_q[req_idx_q] <= (rr_q[req_idx_q] == WAY_BITS'(WAYS - 1)) ?
                                               '0 : rr_q[req_idx_q] + 1'b1;
                        end
                        cpu_rsp_valid <= 1'b1;
                        cpu_rdata     <= req_we_q ? req_wdata_q : mem_rdata;
                        state_q       <= StRespond;
                    end
                end
                StRespond: begin
                    cpu_req_ready <= 1'b1;
                    state_q       <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Data and tag arrays carry no reset; a write miss installs the merged word directly.
    always_ff @(posedge clk) begin
        if (state_q == StCompare && req_hit_q && req_we_q) begin
            data_q[req_idx_q][way_q] <= req_wdata_q;
        end
        if (state_q == StRefill && mem_req_valid && mem_ack) begin
            data_q[req_idx_q][way_q] <= req_we_q ? req_wdata_q : mem_rdata;
            tag_q[req_idx_q][way_q]  <= req_tag_q;
        end
    end

endmodule

// File: tb/tb_assoc_wb_cache.sv
// Bench for assoc_wb_cache: a 2-way instance (index 0) and a 1-way instance (index 1) each
// talk to a memory model that acks three cycles after seeing a request.
module tb_assoc_wb_cache;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic        c_valid [2];
    logic        c_ready [2];
    logic [15:0] c_addr  [2];
    logic        c_we    [2];
    logic [31:0] c_wdata [2];
    logic        r_valid [2];
    logic [31:0] r_data  [2];
    logic        r_hit   [2];
    logic        r_miss  [2];
    logic        m_valid [2];
    logic        m_we    [2];
    logic [15:0] m_addr  [2];
    logic [31:0] m_wdata [2];
    logic        m_ack   [2];
    logic [31:0] m_rdata [2];

    int n_cmp = 0;
    int n_bad = 0;

    assoc_wb_cache #(.WAYS(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n),
        .cpu_req_valid(c_valid[0]), .cpu_req_ready(c_ready[0]), .cpu_addr(c_addr[0]),
        .cpu_we(c_we[0]), .cpu_wdata(c_wdata[0]), .cpu_rsp_valid(r_valid[0]),
        .cpu_rdata(r_data[0]), .hit(r_hit[0]), .miss(r_miss[0]),
        .mem_req_valid(m_valid[0]), .mem_req_we(m_we[0]), .mem_addr(m_addr[0]),
        .mem_wdata(m_wdata[0]), .mem_ack(m_ack[0]), .mem_rdata(m_rdata[0])
    );

    assoc_wb_cache #(.WAYS(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .cpu_req_valid(c_valid[1]), .cpu_req_ready(c_ready[1]), .cpu_addr(c_addr[1]),
        .cpu_we(c_we[1]), .cpu_wdata(c_wdata[1]), .cpu_rsp_valid(r_valid[1]),
        .cpu_rdata(r_data[1]), .hit(r_hit[1]), .miss(r_miss[1]),
        .mem_req_valid(m_valid[1]), .mem_req_we(m_we[1]), .mem_addr(m_addr[1]),
        .mem_wdata(m_wdata[1]), .mem_ack(m_ack[1]), .mem_rdata(m_rdata[1])
    );

    // Memory model: fixed words for a few addresses, otherwise {D00D, addr}.
    logic [31:0] ovr [logic [15:0]];
    int          cnt [2];
    int          wb_cnt [2];
    int          rf_cnt [2];
    logic [15:0] last_wb_addr [2];
    logic [31:0] last_wb_data [2];
    logic [15:0] last_rf_addr [2];

    function automatic logic [31:0] mem_word(input logic [15:0] a);
        if (ovr.exists(a)) return ovr[a];
        return {16'hD00D, a};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < 2; d++) begin
                cnt[d]   <= 0;
                m_ack[d] <= 1'b0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                m_ack[d] <= 1'b0;
                if (m_valid[d] && !m_ack[d]) begin
                    if (cnt[d] == 2) begin
                        m_ack[d]   <= 1'b1;
                        cnt[d]     <= 0;
                        m_rdata[d] <= mem_word(m_addr[d]);
                        if (m_we[d]) begin
                            wb_cnt[d]       <= wb_cnt[d] + 1;
                            last_wb_addr[d] <= m_addr[d];
                            last_wb_data[d] <= m_wdata[d];
                        end else begin
                            rf_cnt[d]       <= rf_cnt[d] + 1;
                            last_rf_addr[d] <= m_addr[d];
                        end
                    end else begin
                        cnt[d] <= cnt[d] + 1;
                    end
                end else begin
                    cnt[d] <= 0;
                end
            end
        end
    end

    // One CPU transaction; lat counts cycles from acceptance to the response pulse.
    task automatic do_req(input int d, input logic [15:0] a, input logic we,
                          input logic [31:0] wd, output logic [31:0] rd, output logic h,
                          output logic m, output int lat, output logic memseen,
                          output logic ok);
        ok = 1'b0; m = 1'b0; h = 1'b0; memseen = 1'b0; rd = '0; lat = 0;
        @(negedge clk);
        c_valid[d] = 1'b1; c_addr[d] = a; c_we[d] = we; c_wdata[d] = wd;
        for (int i = 0; i < 20 && !c_ready[d]; i++) @(negedge clk);
        if (!c_ready[d]) begin
            c_valid[d] = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        c_valid[d] = 1'b0;
        lat = 1;
        for (int i = 0; i < 50; i++) begin
            if (r_miss[d]) m = 1'b1;
            if (m_valid[d]) memseen = 1'b1;
            if (r_valid[d]) begin
                rd = r_data[d]; h = r_hit[d]; ok = 1'b1;
                break;
            end
            @(negedge clk);
            lat++;
        end
    endtask

    logic [31:0] rd;
    logic        h, m, ms, ok;
    int          lat, wb0, rf0;

    task automatic test_reset();
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            c_valid[d] = 1'b0; c_addr[d] = '0; c_we[d] = 1'b0; c_wdata[d] = '0;
        end
        repeat (3) @(negedge clk);
        n_cmp++; if (c_ready[0] !== 1'b0) begin n_bad++; $display("FAIL rst_ready_low: got %b want 0", c_ready[0]); end
        n_cmp++; if (m_valid[0] !== 1'b0) begin n_bad++; $display("FAIL rst_mem_valid: got %b want 0", m_valid[0]); end
        n_cmp++; if (r_valid[0] !== 1'b0) begin n_bad++; $display("FAIL rst_rsp_valid: got %b want 0", r_valid[0]); end
        n_cmp++; if (r_miss[0] !== 1'b0) begin n_bad++; $display("FAIL rst_miss: got %b want 0", r_miss[0]); end
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (c_ready[0] !== 1'b1) begin n_bad++; $display("FAIL rst_ready_after: got %b want 1", c_ready[0]); end
    endtask

    task automatic test_read_miss();
        wb0 = wb_cnt[0]; rf0 = rf_cnt[0];
        do_req(0, 16'h0010, 1'b0, '0, rd, h, m, lat, ms, ok);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL rdmiss_rsp: got %b want 1 (timeout)", ok); end
        n_cmp++; if (m !== 1'b1) begin n_bad++; $display("FAIL rdmiss_miss: got %b want 1", m); end
        n_cmp++; if (h !== 1'b0) begin n_bad++; $display("FAIL rdmiss_hit: got %b want 0", h); end
        n_cmp++; if (rd !== 32'hAABBCCDD) begin n_bad++; $display("FAIL rdmiss_data: got %h want aabbccdd", rd); end
        n_cmp++; if (rf_cnt[0] - rf0 !== 1) begin n_bad++; $display("FAIL rdmiss_refills: got %0d want 1", rf_cnt[0] - rf0); end
        n_cmp++; if (wb_cnt[0] - wb0 !== 0) begin n_bad++; $display("FAIL rdmiss_wbs: got %0d want 0", wb_cnt[0] - wb0); end
        n_cmp++; if (last_rf_addr[0] !== 16'h0010) begin n_bad++; $display("FAIL rdmiss_addr: got %h want 0010", last_rf_addr[0]); end
    endtask

    task automatic test_read_hit();
        do_req(0, 16'h0010, 1'b0, '0, rd, h, m, lat, ms, ok);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL rdhit_rsp: got %b want 1 (timeout)", ok); end
        n_cmp++; if (h !== 1'b1) begin n_bad++; $display("FAIL rdhit_hit: got %b want 1", h); end
        n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL rdhit_latency: got %0d want 1", lat); end
        n_cmp++; if (rd !== 32'hAABBCCDD) begin n_bad++; $display("FAIL rdhit_data: got %h want aabbccdd", rd); end
        n_cmp++; if (ms !== 1'b0) begin n_bad++; $display("FAIL rdhit_memreq: got %b want 0", ms); end
        n_cmp++; if (m !== 1'b0) begin n_bad++; $display("FAIL rdhit_miss: got %b want 0", m); end
    endtask

    task automatic test_writeback();
        do_req(0, 16'h0010, 1'b1, 32'h11223344, rd, h, m, lat, ms, ok);
        n_cmp++; if (h !== 1'b1 || lat !== 1) begin n_bad++; $display("FAIL wrhit: got hit=%b lat=%0d want hit=1 lat=1", h, lat); end
        wb0 = wb_cnt[0];
        do_req(0, 16'h1010, 1'b0, '0, rd, h, m, lat, ms, ok);
        n_cmp++; if (m !== 1'b1 || rd !== {16'hD00D, 16'h1010}) begin n_bad++; $display("FAIL fill_way1: got miss=%b data=%h want miss=1 data=d00d1010", m, rd); end
        n_cmp++; if (wb_cnt[0] - wb0 !== 0) begin n_bad++; $display("FAIL fill_way1_wbs: got %0d want 0", wb_cnt[0] - wb0); end
        do_req(0, 16'h2010, 1'b0, '0, rd, h, m, lat, ms, ok);
        n_cmp++; if (wb_cnt[0] - wb0 !== 1) begin n_bad++; $display("FAIL evict_wbs: got %0d want 1", wb_cnt[0] - wb0); end
        n_cmp++; if (last_wb_addr[0] !== 16'h0010) begin n_bad++; $display("FAIL evict_wb_addr: got %h want 0010", last_wb_addr[0]); end
        n_cmp++; if (last_wb_data[0] !== 32'h11223344) begin n_bad++; $display("FAIL evict_wb_data: got %h want 11223344", last_wb_data[0]); end
        n_cmp++; if (last_rf_addr[0] !== 16'h2010) begin n_bad++; $display("FAIL evict_rf_addr: got %h want 2010", last_rf_addr[0]); end
        n_cmp++; if (rd !== {16'hD00D, 16'h2010} || h !== 1'b0) begin n_bad++; $display("FAIL evict_rsp: got data=%h hit=%b want d00d2010 hit=0", rd, h); end
        // Way 1 (0x1010) must survive the eviction of way 0.
        do_req(0, 16'h1010, 1'b0, '0, rd, h, m, lat, ms, ok);
        n_cmp++; if (h !== 1'b1 || rd !== {16'hD00D, 16'h1010}) begin n_bad++; $display("FAIL way1_kept: got hit=%b data=%h want hit=1 d00d1010", h, rd); end
    endtask

    task automatic test_write_miss();
        rf0 = rf_cnt[0];
        do_req(0, 16'h0020, 1'b1, 32'hCAFEF00D, rd, h, m, lat, ms, ok);
        n_cmp++; if (m !== 1'b1 || h !== 1'b0) begin n_bad++; $display("FAIL wrmiss_flags: got miss=%b hit=%b want 1/0", m, h); end
        n_cmp++; if (rf_cnt[0] - rf0 !== 1 || last_rf_addr[0] !== 16'h0020) begin n_bad++; $display("FAIL wrmiss_refill: got n=%0d addr=%h want 1 0020", rf_cnt[0] - rf0, last_rf_addr[0]); end
        n_cmp++; if (rd !== 32'hCAFEF00D) begin n_bad++; $display("FAIL wrmiss_rdata: got %h want cafef00d", rd); end
        do_req(0, 16'h0020, 1'b0, '0, rd, h, m, lat, ms, ok);
        n_cmp++; if (h !== 1'b1 || rd !== 32'hCAFEF00D) begin n_bad++; $display("FAIL wrmiss_readback: got hit=%b data=%h want 1 cafef00d", h, rd); end
    endtask

    task automatic test_reset_mid_refill();
        logic seen;
        seen = 1'b0;
        @(negedge clk);
        c_valid[0] = 1'b1; c_addr[0] = 16'h0030; c_we[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        c_valid[0] = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (m_valid[0]) seen = 1'b1;
            else @(negedge clk);
        end
        n_cmp++; if (seen !== 1'b1) begin n_bad++; $display("FAIL midrst_req_seen: got %b want 1", seen); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (m_valid[0] !== 1'b0) begin n_bad++; $display("FAIL midrst_mem_drop: got %b want 0", m_valid[0]); end
        n_cmp++; if (c_ready[0] !== 1'b0) begin n_bad++; $display("FAIL midrst_ready: got %b want 0", c_ready[0]); end
        @(negedge clk);
        rst_n = 1'b1;
        do_req(0, 16'h0010, 1'b0, '0, rd, h, m, lat, ms, ok);
        n_cmp++; if (m !== 1'b1 || h !== 1'b0 || ok !== 1'b1) begin n_bad++; $display("FAIL midrst_cold: got miss=%b hit=%b ok=%b want 1/0/1", m, h, ok); end
    endtask

    task automatic test_direct_mapped();
        logic [15:0] a;
        int nmiss;
        int ngood;
        nmiss = 0; ngood = 0;
        wb0 = wb_cnt[1]; rf0 = rf_cnt[1];
        for (int i = 0; i < 8; i++) begin
            a = (i % 2 == 0) ? 16'h0010 : 16'h1010;
            do_req(1, a, 1'b0, '0, rd, h, m, lat, ms, ok);
            if (m === 1'b1 && h === 1'b0) nmiss++;
            if (ok === 1'b1 && rd === mem_word(a)) ngood++;
        end
        n_cmp++; if (nmiss !== 8) begin n_bad++; $display("FAIL dm_misses: got %0d want 8", nmiss); end
        n_cmp++; if (ngood !== 8) begin n_bad++; $display("FAIL dm_data: got %0d good want 8", ngood); end
        n_cmp++; if (wb_cnt[1] - wb0 !== 0) begin n_bad++; $display("FAIL dm_wbs: got %0d want 0", wb_cnt[1] - wb0); end
        n_cmp++; if (rf_cnt[1] - rf0 !== 8) begin n_bad++; $display("FAIL dm_refills: got %0d want 8", rf_cnt[1] - rf0); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        ovr[16'h0010] = 32'hAABBCCDD;
        test_reset();
        test_read_miss();
        test_read_hit();
        test_writeback();
        test_write_miss();
        test_reset_mid_refill();
        test_direct_mapped();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
